// File: rtl/rle_cmd_feeder_if.sv
// ---------------------------------------------------------------------------
// rle_cmd_feeder_if
// Bundles the host byte stream and the repeater run handshake of the
// run-length command feeder.
//   in_data/in_valid/in_ready/in_sync : command bytes from the host interface
//   run_count/run_value/run_enable    : run issued to the repeater
//   run_done                          : repeater finished the current run
//   fifo_level/busy                   : status
// Modports: slave = the feeder itself, master = host + repeater side.
// ---------------------------------------------------------------------------
interface rle_cmd_feeder_if #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4
);
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic            in_sync;
    logic [9:0]      run_count;
    logic [5:0]      run_value;
    logic            run_enable;
    logic            run_done;
    logic [ADDR_W:0] fifo_level;
    logic            busy;

    modport slave (
        input  in_data, in_valid, in_sync, run_done,
        output in_ready, run_count, run_value, run_enable, fifo_level, busy
    );

    modport master (
        output in_data, in_valid, in_sync, run_done,
        input  in_ready, run_count, run_value, run_enable, fifo_level, busy
    );
endinterface

// File: rtl/rle_cmd_feeder.sv
// ---------------------------------------------------------------------------
// rle_cmd_feeder
// Assembles 2-byte run commands {value, repeat_count} from the host byte
// stream, buffers them in a FIFO and issues them one at a time to the
// run-length repeater: a one-cycle run_enable pulse, then wait for run_done.
//   byte0 = {value[5:0], count[9:8]}, byte1 = count[7:0]
// Ports:
//   clk   : system clock, all state changes on posedge
//   rst_n : asynchronous reset, active low
//   bus   : rle_cmd_feeder_if.slave (host bytes, repeater handshake, status)
// Parameters: FIFO_DEPTH (power of two, >= 2), ADDR_W = log2(FIFO_DEPTH).
// Optional feature: define RLE_ZERO_SKIP_EN to drop count==0 commands at
// byte1 instead of buffering and issuing them.
// ---------------------------------------------------------------------------
module rle_cmd_feeder #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    rle_cmd_feeder_if.slave  bus
);
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    // FIFO storage: {count[9:0], value[5:0]}
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q, level_d;

    // Byte assembler
    logic              have_byte0_q;
    logic [7:0]        byte0_q;

    // Issue FSM and registered outputs
    state_e            state_q;
    logic [9:0]        run_count_q;
    logic [5:0]        run_value_q;
    logic              run_enable_q;
    logic              busy_q;

    logic              full, empty, accept, wr_en, pop, cmd_keep;
    logic [9:0]        cmd_count;
    logic [5:0]        cmd_value;
    logic [15:0]       head;

    assign full      = (level_q == FULL_LEVEL);
    assign empty     = (level_q == '0);
    assign accept    = bus.in_valid && !full;
    assign cmd_count = {byte0_q[1:0], bus.in_data};
    assign cmd_value = byte0_q[7:2];
    assign head      = mem_q[rd_ptr_q];

`ifdef RLE_ZERO_SKIP_EN
    assign cmd_keep = (cmd_count != 10'd0);
`else
    assign cmd_keep = 1'b1;
`endif

    // A byte arriving with in_sync is always byte0, so it never completes a command.
    assign wr_en = accept && !bus.in_sync && have_byte0_q && cmd_keep;
    assign pop   = (state_q == StIdle) && !empty;

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop) begin
            level_d = level_q + (ADDR_W + 1)'(1);
        end else if (!wr_en && pop) begin
            level_d = level_q - (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {cmd_count, cmd_value};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            level_q <= level_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            end
        end
    end

    // Assembler: a dropped zero-count command still consumes its byte1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_byte0_q <= 1'b0;
            byte0_q      <= '0;
        end else if (bus.in_sync) begin
            have_byte0_q <= accept;
            if (accept) begin
                byte0_q <= bus.in_data;
            end
        end else if (accept) begin
            if (!have_byte0_q) begin
                byte0_q      <= bus.in_data;
                have_byte0_q <= 1'b1;
            end else begin
                have_byte0_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            run_count_q  <= '0;
            run_value_q  <= '0;
            run_enable_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            run_enable_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        run_count_q  <= head[15:6];
                        run_value_q  <= head[5:0];
                        run_enable_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (bus.run_done) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = !full;
    assign bus.run_count  = run_count_q;
    assign bus.run_value  = run_value_q;
    assign bus.run_enable = run_enable_q;
    assign bus.fifo_level = level_q;
    assign bus.busy       = busy_q;
endmodule
